// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_e;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Encoding 11 is an alias for a word access.
    function automatic size_e norm_size(input logic [1:0] raw);
        case (raw)
            2'b00:   norm_size = SZ_BYTE;
            2'b01:   norm_size = SZ_HALF;
            default: norm_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] lane);
        case (sz)
            SZ_BYTE: lane_mask = MASK_BYTE << lane;
            SZ_HALF: lane_mask = MASK_HALF << {lane[1], 1'b0};
            default: lane_mask = MASK_WORD;
        endcase
    endfunction

    function automatic logic [31:0] byte_bits(input logic [3:0] m);
        byte_bits = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane extract (load extend) and lane merge (sub-word store word).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [1:0]  lane,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] ext_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] wrep_s;
    logic [31:0] bmask_s;

    // Pick the addressed lane and sign/zero extend it.
    always_comb begin
        byte_s = rd_word[{lane, 3'b000} +: 8];
        half_s = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            SZ_BYTE: ext_data = {{24{~is_unsigned & byte_s[7]}}, byte_s};
            SZ_HALF: ext_data = {{16{~is_unsigned & half_s[15]}}, half_s};
            default: ext_data = rd_word;
        endcase
    end

    // Replicate store data across lanes, then keep only the target lanes.
    always_comb begin
        case (size)
            SZ_BYTE: wrep_s = {4{wdata[7:0]}};
            SZ_HALF: wrep_s = {2{wdata[15:0]}};
            default: wrep_s = wdata;
        endcase
        bmask_s    = byte_bits(lane_mask(size, lane));
        merge_data = (rd_word & ~bmask_s) | (wrep_s & bmask_s);
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller FSM: one request at a time, read-modify-write for sub-word stores.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_READ  = READ;
    localparam logic [1:0] ST_WRITE = WRITE;
    localparam logic [1:0] ST_RESP  = RESP;

    logic [1:0]        state_r;
    logic [1:0]        state_nx_s;
    logic              we_r;
    logic              uns_r;
    size_e             size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rword_r;
    logic              err_r;
    logic              hs_s;
    logic              misalign_s;
    logic [31:0]       ext_s;
    logic [31:0]       merge_s;

    assign hs_s = req_valid && (state_r == ST_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    // Half needs addr[0]=0, word needs addr[1:0]=00.
    always_comb begin
        case (norm_size(req_size))
            SZ_HALF: misalign_s = req_addr[0];
            SZ_WORD: misalign_s = (req_addr[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
    end
`else
    assign misalign_s = 1'b0;
`endif

    // Next-state decode; word stores skip the read, traps go straight to RESP.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    if (misalign_s) begin
                        state_nx_s = ST_RESP;
                    end else if (req_we && (norm_size(req_size) == SZ_WORD)) begin
                        state_nx_s = ST_WRITE;
                    end else begin
                        state_nx_s = ST_READ;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_READ:  state_nx_s = we_r ? ST_WRITE : ST_RESP;
            ST_WRITE: state_nx_s = ST_RESP;
            ST_RESP:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // State, request capture and read-word capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            we_r    <= 1'b0;
            uns_r   <= 1'b0;
            size_r  <= SZ_BYTE;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            rword_r <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (hs_s) begin
                we_r    <= req_we;
                uns_r   <= req_unsigned;
                size_r  <= norm_size(req_size);
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                err_r   <= misalign_s;
            end
            if (state_r == ST_READ) begin
                rword_r <= mem_rd_data;
            end
        end
    end

    lsu_lane_align u_align (
        .size        (size_r),
        .is_unsigned (uns_r),
        .lane        (addr_r[1:0]),
        .rd_word     (rword_r),
        .wdata       (wdata_r),
        .ext_data    (ext_s),
        .merge_data  (merge_s)
    );

    // Outputs decode from registered state only, so req_* never reaches mem_*.
    always_comb begin
        req_ready   = (state_r == ST_IDLE);
        mem_we      = (state_r == ST_WRITE);
        if ((state_r == ST_READ) || (state_r == ST_WRITE)) begin
            mem_addr = {addr_r[ADDR_W-1:2], 2'b00};
        end else begin
            mem_addr = {ADDR_W{1'b0}};
        end
        mem_wr_data = (state_r == ST_WRITE) ? merge_s : {DATA_W{1'b0}};
        resp_valid  = (state_r == ST_RESP);
        resp_err    = (state_r == ST_RESP) && err_r;
        if ((state_r == ST_RESP) && !we_r && !err_r) begin
            resp_rdata = ext_s;
        end else begin
            resp_rdata = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: byte-array memory model with per-cycle expectations.
module tb_lsu_ctrl;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    logic        pin_en = 1'b0;
    logic [31:0] pin_val = 32'h0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 1) return 32'h11223344;
        if (i == 3) return 32'h80017FFE;
        return 32'hA5000000 | 32'(i);
    endfunction

    // Simple RAM the DUT talks to.
    logic [31:0] ram [16];
    bit ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr[5:2]] <= mem_wr_data;
        end
    end
    assign mem_rd_data = ram[mem_addr[5:2]];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state.
    typedef struct packed { logic [31:0] addr; logic we; logic [31:0] data; } mexp_t;
    typedef struct packed { logic [31:0] rdata; logic err; } rexp_t;
    mexp_t mq [int];
    rexp_t rq [int];
    logic [7:0] mb [64];
    bit mdl_init = 1'b0;
    int busy_until = -1;
    int stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int c;
        int ks[$];
        c = cyc;
        if (!mdl_init) begin
            for (int i = 0; i < 64; i++) mb[i] = 8'(init_word(i / 4) >> (8 * (i % 4)));
            mdl_init = 1'b1;
        end
        if (!rst_n) begin
            ks.delete();
            foreach (mq[k]) if (k >= c) ks.push_back(k);
            foreach (ks[j]) mq.delete(ks[j]);
            ks.delete();
            foreach (rq[k]) if (k >= c) ks.push_back(k);
            foreach (ks[j]) rq.delete(ks[j]);
            busy_until = c - 1;
        end
        chk("ready", {31'h0, req_ready}, {31'h0, c > busy_until});
        if (mq.exists(c)) begin
            chk("mem_addr", mem_addr, mq[c].addr);
            chk("mem_we", {31'h0, mem_we}, {31'h0, mq[c].we});
            chk("mem_wr_data", mem_wr_data, mq[c].data);
            if (mq[c].we) begin
                for (int i = 0; i < 4; i++) mb[int'(mq[c].addr[5:0]) + i] = mq[c].data[8*i +: 8];
            end
            mq.delete(c);
        end else begin
            chk("mem_idle_we", {31'h0, mem_we}, 32'h0);
            chk("mem_idle_addr", mem_addr, 32'h0);
            chk("mem_idle_wdata", mem_wr_data, 32'h0);
        end
        if (rq.exists(c)) begin
            chk("resp_valid", {31'h0, resp_valid}, 32'h1);
            chk("resp_rdata", resp_rdata, rq[c].rdata);
            chk("resp_err", {31'h0, resp_err}, {31'h0, rq[c].err});
            rq.delete(c);
        end else begin
            chk("resp_idle_valid", {31'h0, resp_valid}, 32'h0);
            chk("resp_idle_rdata", resp_rdata, 32'h0);
            chk("resp_idle_err", {31'h0, resp_err}, 32'h0);
        end
        if (req_valid && !req_ready) stall++; else stall = 0;
        if (stall == 20) begin
            total++;
            bad++;
            $display("FAIL stall cyc=%0d got=not_ready want=ready", c);
        end
        if (rst_n && req_valid && req_ready) begin
            int a, nb, base, wb;
            logic [31:0] v;
            logic [7:0] nw [4];
            bit mis;
            a = int'(req_addr[5:0]);
            nb = (req_size == 2'b00) ? 1 : (req_size == 2'b01) ? 2 : 4;
            base = a - (a % nb);
            wb = a - (a % 4);
            mis = TRAP && ((a % nb) != 0);
            v = 32'h0;
            if (mis) begin
                rq[c+1] = '{rdata: 32'h0, err: 1'b1};
                busy_until = c + 1;
            end else if (!req_we) begin
                for (int i = 0; i < nb; i++) v = v | (32'(mb[base + i]) << (8 * i));
                if (!req_unsigned && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
                mq[c+1] = '{addr: 32'(wb), we: 1'b0, data: 32'h0};
                rq[c+2] = '{rdata: v, err: 1'b0};
                busy_until = c + 2;
            end else begin
                for (int i = 0; i < 4; i++) nw[i] = mb[wb + i];
                for (int i = 0; i < nb; i++) nw[base - wb + i] = req_wdata[8*i +: 8];
                v = {nw[3], nw[2], nw[1], nw[0]};
                if (nb == 4) begin
                    mq[c+1] = '{addr: 32'(wb), we: 1'b1, data: v};
                    rq[c+2] = '{rdata: 32'h0, err: 1'b0};
                    busy_until = c + 2;
                end else begin
                    mq[c+1] = '{addr: 32'(wb), we: 1'b0, data: 32'h0};
                    mq[c+2] = '{addr: 32'(wb), we: 1'b1, data: v};
                    rq[c+3] = '{rdata: 32'h0, err: 1'b0};
                    busy_until = c + 3;
                end
            end
            if (pin_en) chk("model_pin", v, pin_val);
        end
    end

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] pv, input bit abort);
        int w;
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        pin_en = 1'b1; pin_val = pv; req_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 30) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        pin_en = 1'b0;
        if (abort) begin
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        //     we    size   uns   addr        wdata         pinned model value             abort
        do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0,       32'hDEADBEEF, 1'b0);
        do_req(1'b1, 2'b00, 1'b0, 32'h06, 32'h000000AA, 32'h11AA3344, 1'b0);
        do_req(1'b0, 2'b00, 1'b0, 32'h06, 32'h0,       32'hFFFFFFAA, 1'b0);
        do_req(1'b0, 2'b00, 1'b1, 32'h06, 32'h0,       32'h000000AA, 1'b0);
        do_req(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0,       32'hFFFF8001, 1'b0);
        do_req(1'b0, 2'b01, 1'b0, 32'h0C, 32'h0,       32'h00007FFE, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h05, 32'h0,       TRAP ? 32'h0 : 32'h11AA3344, 1'b0);
        do_req(1'b1, 2'b01, 1'b0, 32'h0E, 32'hFFFF1234, 32'h12347FFE, 1'b0);
        do_req(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0,       32'h00001234, 1'b0);
        do_req(1'b0, 2'b11, 1'b0, 32'h0C, 32'h0,       32'h12347FFE, 1'b0);
        do_req(1'b1, 2'b01, 1'b0, 32'h03, 32'h0000BEEF, TRAP ? 32'h0 : 32'hBEEF0000, 1'b0);
        do_req(1'b0, 2'b01, 1'b1, 32'h02, 32'h0,       TRAP ? 32'h0000A500 : 32'h0000BEEF, 1'b0);
        do_req(1'b1, 2'b00, 1'b0, 32'h04, 32'h00000077, 32'h11AA3377, 1'b1);
        do_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0,       32'h11AA3344, 1'b0);
        do_req(1'b0, 2'b00, 1'b0, 32'h0F, 32'h0,       32'h00000012, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller sitting between the CPU execute stage and the word-addressed data memory. It accepts one byte/half/word load or store request at a time and drives the memory's `we`/`addr`/`wr_data` interface. It extracts and extends load data from the combinationally-read `rd_data`, and performs read-modify-write for sub-word stores. It issues one single-cycle response per accepted request.

## Interface
- Parameters:
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, data/word width; fixed at 32, other values unsupported.
- Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; handshake = `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- `req_unsigned`  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-aligned (bits [7:0] for byte stores).
- `resp_valid`  out  1  one-cycle pulse per accepted request; no backpressure.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned access (see Configuration).
- `mem_we`  out  1  memory write enable, sampled by memory on posedge.
- `mem_addr`  out  ADDR_W  word-aligned byte address, bits [1:0] = 00.
- `mem_wr_data`  out  32  write word.
- `mem_rd_data`  in  32  combinational read data for `mem_addr`.

## Operation
- States: IDLE, READ, WRITE, RESP.
- On handshake, the following are captured: `we`, `size`, `unsigned`, `addr`, `wdata`. Lane = `addr[1:0]`, little-endian; byte k occupies bits [8k+7:8k].
- Transitions on handshake:
  - Load: IDLE→READ→RESP→IDLE.
  - Sub-word store: IDLE→READ→WRITE→RESP→IDLE.
  - Word store: IDLE→WRITE→RESP→IDLE; no read.
  - Misaligned access with trap enabled: IDLE→RESP→IDLE.
- READ:
  - `mem_addr = {addr[ADDR_W-1:2],2'b00}`.
  - `mem_rd_data` is registered at the end of the cycle.
- WRITE:
  - `mem_we=1` for exactly one cycle.
  - `mem_wr_data`:
    - Word store: store data as-is.
    - Sub-word store: captured read word with the target byte/half lanes replaced by `wdata[7:0]` or `wdata[15:0]`.
- RESP:
  - `resp_valid=1`.
  - For loads, `resp_rdata` = selected lane, extended to 32 bits.
  - Half lane uses `addr[1]`.
- Outside READ/WRITE: `mem_addr=0`, `mem_wr_data=0`, `mem_we=0`.
- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `mem_we=0`, `mem_addr=0`, `mem_wr_data=0`.
- Reset asserted mid-operation: returns to IDLE immediately. No `mem_we` pulse and no response are produced for the aborted request.
- `req_valid` while not IDLE is ignored; the requester holds the request until `req_ready`.

## Timing
- Handshake at cycle N:
  - Load: `resp_valid` at N+2.
  - Word store: `mem_we` at N+1, `resp_valid` at N+2.
  - Sub-word store: read at N+1, `mem_we` at N+2, `resp_valid` at N+3.
  - Misaligned trap: `resp_valid` at N+1.
- Next handshake is possible the cycle after RESP.
- Back-to-back throughput: one load per 3 cycles.
- `resp_rdata` and `resp_err` are valid only while `resp_valid=1`; both are 0 otherwise.
- All outputs are registered or decoded from state; there is no combinational path from `req_*` to `mem_*`.

## Configuration
- Macro `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - Half access with `addr[0]=1`, or word access with `addr[1:0]≠00`, does not touch memory.
  - The response is `resp_err=1`, `resp_rdata=0`.
- Undefined:
  - Half accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`.
  - `resp_err` is tied 0.

## Structure
- Package `lsu_pkg`:
  - `size_e` (SZ_BYTE, SZ_HALF, SZ_WORD).
  - `state_e` (IDLE, READ, WRITE, RESP).
  - Lane mask constants.
- Sub-module `lsu_lane_align`: purely combinational.
  - `extract`: lane select and sign/zero extension.
  - `merge`: lane insert for store words.
- The FSM and registers stay in `lsu_ctrl`.

## Test plan
- Word store then load: store addr 0x08, data 0xDEADBEEF → `mem_we` at N+1 with `mem_addr=0x08`; load 0x08 → `resp_rdata=0xDEADBEEF` at N+2.
- Byte store and merge: memory[0x04]=0x11223344; store byte 0xAA at 0x06 → write word 0x11AA3344; load byte signed 0x06 → 0xFFFFFFAA; unsigned → 0x000000AA.
- Half load: memory[0x0C]=0x8001_7FFE; signed half 0x0E → 0xFFFF8001; signed half 0x0C → 0x00007FFE.
- Misaligned word load at 0x05:
  - With macro: `resp_err=1`, `rdata=0`, no memory access, response at N+1.
  - Without macro: reads 0x04 with `resp_err=0`.
- Reset mid-store: assert `rst_n` low during READ of a byte store → no `mem_we` pulse, no `resp_valid`; after release `req_ready=1` and all outputs are 0.
- Busy ignore: hold `req_valid` with a second request during READ → the request is accepted only after RESP, and exactly one response is produced per handshake.
